vram_arbiter: RTL
=================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameters, all in vram_pkg:
- FB_W, 160, framebuffer width in words.
- FB_H, 120, framebuffer height in words.
- FB_DEPTH, 19200, total framebuffer words.
- ADDR_W, 15, framebuffer address width.
REQ-002 Ports; one clock; reset is synchronous and active-high:
- clk_50MHz  in  1  sole clock.
- RESET  in  1  synchronous, active-high reset.
- CURX  in  10  current display X from the VGA driver.
- CURY  in  9  current display Y from the VGA driver.
- HBLANK  in  1  horizontal blanking from the VGA driver.
- VBLANK  in  1  vertical blanking from the VGA driver.
- COLOR  out  8  RGB332 pixel to the VGA driver.
- WA_REQ  in  1  writer A request.
- WA_ADDR  in  15  writer A address.
- WA_DATA  in  8  writer A data.
- WA_ACK  out  1  writer A acknowledge.
- WB_REQ  in  1  writer B request.
- WB_ADDR  in  15  writer B address.
- WB_DATA  in  8  writer B data.
- WB_ACK  out  1  writer B acknowledge.
- CLR_START  in  1  clear-engine start pulse.
- CLR_COLOR  in  8  fill value for clear.
- CLR_BUSY  out  1  clear engine active.
- MEM_ADDR  out  15  single-port VRAM address.
- MEM_WE  out  1  VRAM write enable.
- MEM_WDATA  out  8  VRAM write data.
- MEM_RDATA  in  8  VRAM read data, valid 1 cycle after address.

Function
REQ-003 The block SHALL compute the display address as (CURY>>2)*FB_W + (CURX>>2), giving a 4x4 pixel upscale of the 160x120 buffer.
REQ-004 A display request SHALL become pending when HBLANK=0, VBLANK=0 and the display address differs from the last-fetched address register.
REQ-005 Exactly one VRAM access SHALL issue per cycle, with priority: display read > writers > clear engine.
REQ-006 A display read SHALL drive MEM_WE=0 and the display address, and SHALL update the last-fetched register in the same cycle.
REQ-007 COLOR SHALL load MEM_RDATA in the cycle after a display read issues, giving 2-cycle latency from the address change to COLOR.
REQ-008 COLOR SHALL be 8'h00 in any cycle after HBLANK or VBLANK has been sampled high.
REQ-009 Entering blanking SHALL invalidate the last-fetched register, so the first active pixel always causes a fetch.
REQ-010 Writer selection SHALL be round-robin between A and B: the last granted writer loses a tie; after reset A is favoured.
REQ-011 A granted writer SHALL see MEM_WE=1 with its ADDR and DATA on MEM_*, and its ACK high for exactly that one cycle.
REQ-012 Each writer SHALL hold REQ, ADDR and DATA stable until ACK; REQ may stay high for back-to-back writes, one per grant.
REQ-013 A writer address >= FB_DEPTH SHALL be acknowledged normally with MEM_WE=0, so the write is dropped.
REQ-014 CLR_START while CLR_BUSY=0 SHALL latch CLR_COLOR, set CLR_BUSY and reset the clear pointer to 0.
REQ-015 CLR_START while CLR_BUSY=1 SHALL be ignored.
REQ-016 The clear engine SHALL write the latched color at the pointer and then increment it, only in cycles with no display or writer access.
REQ-017 CLR_BUSY SHALL fall in the cycle after the write to address FB_DEPTH-1.
REQ-018 Controller states SHALL be:
- IDLE: no access this cycle.
- DISP: display read.
- WRA: writer A write.
- WRB: writer B write.
- CLR: clear-engine write.
REQ-019 The state SHALL be re-evaluated every cycle from the pending requests; no state persists beyond one cycle.
REQ-020 MEM_ADDR SHALL hold its previous value in IDLE, and MEM_WE SHALL be 0 in every state except WRA, WRB and CLR.

Reset
REQ-021 RESET SHALL force, on the next clk_50MHz edge:
- COLOR=0, WA_ACK=0, WB_ACK=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, CLR_BUSY=0.
- Clear pointer = 0.
- Last-fetched register = invalid.
- Round-robin favouring A.
REQ-022 RESET during a clear SHALL abort it and leave the remaining words unwritten.
REQ-023 RESET SHALL take priority over CLR_START and all requests presented in the same cycle.

Structure
REQ-024 vram_pkg SHALL hold FB_W, FB_H, FB_DEPTH and ADDR_W, plus the state enumeration {IDLE, DISP, WRA, WRB, CLR}.
REQ-025 Round-robin selection SHALL be a sub-module vram_rr_pick with inputs req_a, req_b, last_was_a and outputs gnt_a, gnt_b.

Verification
REQ-026 Active video at CURY=8, with CURX stepping 0..7 every 2 cycles -> reads at addresses 320 and 321 only; COLOR equals RDATA 2 cycles after each address change.
REQ-027 WA_REQ held with address 100 and data 8'hE0 during active video, with a display change in the same cycle -> DISP first, then WA_ACK a cycle later with MEM_WE=1, MEM_ADDR=100, MEM_WDATA=E0.
REQ-028 WA_REQ and WB_REQ both held continuously during VBLANK -> ACKs alternate A, B, A, B, with one write every cycle.
REQ-029 WB_ADDR=19200 -> WB_ACK=1 for one cycle with MEM_WE=0.
REQ-030 CLR_START with CLR_COLOR=8'h1C during VBLANK and no writers -> 19200 consecutive writes at 0..19199 of 1C; CLR_BUSY drops one cycle after the last.
REQ-031 RESET asserted at clear pointer 500 -> CLR_BUSY=0 next cycle; no further clear writes; a second CLR_START restarts at address 0.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared framebuffer geometry, controller state encoding and the display
// address helper for the VRAM arbiter.
package vram_pkg;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int ADDR_W   = 15;

  localparam logic [ADDR_W-1:0] FB_END     = ADDR_W'(FB_DEPTH);
  localparam logic [7:0]        COLOR_OFF  = 8'h00;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DISP = 3'd1,
    WRA  = 3'd2,
    WRB  = 3'd3,
    CLR  = 3'd4
  } vram_state_e;

  // Each framebuffer word covers a 4x4 block of screen pixels.
  function automatic logic [ADDR_W-1:0] disp_addr(input logic [9:0] cur_x,
                                                  input logic [8:0] cur_y);
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    row = ADDR_W'(cur_y >> 2);
    col = ADDR_W'(cur_x >> 2);
    return row * ADDR_W'(FB_W) + col;
  endfunction

endpackage

// File: rtl/vram_rr_pick.sv
// Two-way round-robin picker: on a tie the side that won last time loses.
module vram_rr_pick (
  input  logic req_a,
  input  logic req_b,
  input  logic last_was_a,
  output logic gnt_a,
  output logic gnt_b
);

  // Tie goes to whichever writer was not served most recently.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (req_a && req_b) begin
      gnt_a = ~last_was_a;
      gnt_b = last_was_a;
    end else begin
      gnt_a = req_a;
      gnt_b = req_b;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter for a 4x-upscaled 160x120 RGB332 framebuffer.
// One access per cycle: display read, then round-robin writers, then clear.
module vram_arbiter
  import vram_pkg::*;
(
  input  logic              clk_50MHz,
  input  logic              RESET,
  input  logic [9:0]        CURX,
  input  logic [8:0]        CURY,
  input  logic              HBLANK,
  input  logic              VBLANK,
  output logic [7:0]        COLOR,
  input  logic              WA_REQ,
  input  logic [ADDR_W-1:0] WA_ADDR,
  input  logic [7:0]        WA_DATA,
  output logic              WA_ACK,
  input  logic              WB_REQ,
  input  logic [ADDR_W-1:0] WB_ADDR,
  input  logic [7:0]        WB_DATA,
  output logic              WB_ACK,
  input  logic              CLR_START,
  input  logic [7:0]        CLR_COLOR,
  output logic              CLR_BUSY,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_WE,
  output logic [7:0]        MEM_WDATA,
  input  logic [7:0]        MEM_RDATA
);

  logic [ADDR_W-1:0] w_disp_addr;
  logic              w_blank;
  logic              w_disp_pend;
  logic              w_req_a;
  logic              w_req_b;
  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              w_clr_pend;
  logic              w_wa_ok;
  logic              w_wb_ok;
  vram_state_e       w_next;

  vram_state_e       r_state;
  logic [ADDR_W-1:0] r_lf_addr;
  logic              r_lf_valid;
  logic              r_last_was_a;
  logic              r_rd_pend;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [7:0]        r_clr_color;

  assign w_blank     = HBLANK | VBLANK;
  assign w_disp_addr = disp_addr(CURX, CURY);
  assign w_disp_pend = ~w_blank & (~r_lf_valid | (w_disp_addr != r_lf_addr));

  // A request seen while its ACK is high is the one being acknowledged now.
  assign w_req_a    = WA_REQ & ~WA_ACK;
  assign w_req_b    = WB_REQ & ~WB_ACK;
  assign w_clr_pend = CLR_BUSY & (r_clr_ptr != FB_END);
  assign w_wa_ok    = (WA_ADDR < FB_END);
  assign w_wb_ok    = (WB_ADDR < FB_END);

  vram_rr_pick u_rr (
    .req_a      (w_req_a),
    .req_b      (w_req_b),
    .last_was_a (r_last_was_a),
    .gnt_a      (w_gnt_a),
    .gnt_b      (w_gnt_b)
  );

  // Fixed priority between the three access sources.
  always_comb begin
    w_next = IDLE;
    if (w_disp_pend) begin
      w_next = DISP;
    end else if (w_gnt_a) begin
      w_next = WRA;
    end else if (w_gnt_b) begin
      w_next = WRB;
    end else if (w_clr_pend) begin
      w_next = CLR;
    end else begin
      w_next = IDLE;
    end
  end

  // Controller: register the chosen access onto the memory port and ACKs.
  always_ff @(posedge clk_50MHz) begin
    if (RESET) begin
      r_state      <= IDLE;
      MEM_ADDR     <= {ADDR_W{1'b0}};
      MEM_WE       <= 1'b0;
      MEM_WDATA    <= 8'h00;
      WA_ACK       <= 1'b0;
      WB_ACK       <= 1'b0;
      r_last_was_a <= 1'b0;
    end else begin
      r_state <= w_next;
      WA_ACK  <= (w_next == WRA);
      WB_ACK  <= (w_next == WRB);
      case (w_next)
        DISP: begin
          MEM_ADDR <= w_disp_addr;
          MEM_WE   <= 1'b0;
        end
        WRA: begin
          MEM_ADDR     <= WA_ADDR;
          MEM_WE       <= w_wa_ok;
          MEM_WDATA    <= WA_DATA;
          r_last_was_a <= 1'b1;
        end
        WRB: begin
          MEM_ADDR     <= WB_ADDR;
          MEM_WE       <= w_wb_ok;
          MEM_WDATA    <= WB_DATA;
          r_last_was_a <= 1'b0;
        end
        CLR: begin
          MEM_ADDR  <= r_clr_ptr;
          MEM_WE    <= 1'b1;
          MEM_WDATA <= r_clr_color;
        end
        default: begin
          MEM_WE <= 1'b0;
        end
      endcase
    end
  end

  // Display fetch tracking, pixel output and the clear engine.
  always_ff @(posedge clk_50MHz) begin
    if (RESET) begin
      r_lf_valid  <= 1'b0;
      r_lf_addr   <= {ADDR_W{1'b0}};
      r_rd_pend   <= 1'b0;
      COLOR       <= COLOR_OFF;
      CLR_BUSY    <= 1'b0;
      r_clr_ptr   <= {ADDR_W{1'b0}};
      r_clr_color <= 8'h00;
    end else begin
      // RDATA for the address presented last cycle is valid now.
      r_rd_pend <= (r_state == DISP);
      if (w_blank) begin
        COLOR <= COLOR_OFF;
      end else if (r_rd_pend) begin
        COLOR <= MEM_RDATA;
      end

      if (w_blank) begin
        r_lf_valid <= 1'b0;
      end else if (w_next == DISP) begin
        r_lf_valid <= 1'b1;
        r_lf_addr  <= w_disp_addr;
      end

      if (!CLR_BUSY) begin
        if (CLR_START) begin
          CLR_BUSY    <= 1'b1;
          r_clr_color <= CLR_COLOR;
          r_clr_ptr   <= {ADDR_W{1'b0}};
        end
      end else if (w_next == CLR) begin
        r_clr_ptr <= r_clr_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else if (!w_clr_pend) begin
        CLR_BUSY <= 1'b0;
      end
    end
  end

endmodule
